usart_rx: RTL

Serial receiver that consumes the 8N1 frames produced by `usart_tx`. It oversamples the line at 16x the bit rate and takes a 3-sample majority vote at each bit centre. Each valid byte is presented on a parallel port with a level-held ready flag, and framing and overrun errors are reported. It sits between the external RX pin and the host-side register or FIFO logic of the USART.

---
 rtl/usart_rx.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/usart_rx.sv
// usart_rx: 8N1 serial receiver.
// The line is sampled at 16x the bit rate. Each bit is resolved by a
// 3-sample majority vote at ticks 7/8/9 of the bit. Received bytes are
// held on data_out with a level-held data_ready flag. Framing and overrun
// errors are reported as sticky flags, which ack_in clears.
module usart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       bit_clock_x16,
    input  logic       reset_n,
    input  logic       rx_pin,
    input  logic       ack_in,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       receiving
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    // Majority of three samples; tolerates a single corrupted sample.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q, state_d;
    logic [3:0]             tick_q, tick_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [1:0]             samp_q, samp_d;     // [1] = tick 7 sample, [0] = tick 8 sample
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   ready_q, ready_d;
    logic                   fe_q, fe_d;
    logic                   ovr_q, ovr_d;
    logic                   rcv_q, rcv_d;

    logic                   rx_s;
    logic                   vote_s;
    logic                   commit_s;
    logic                   frame_err_s;

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign vote_s = maj3(samp_q[1], samp_q[0], rx_s);

    // Synchroniser for the asynchronous pin; resets to the idle (high) level.
    always_ff @(posedge bit_clock_x16 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin};
        end
    end

    // Receive FSM next-state, tick/bit counters, sampling and shifting.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q + 4'd1;
        bit_idx_d   = bit_idx_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        commit_s    = 1'b0;
        frame_err_s = 1'b0;

        if (tick_q == 4'd7) begin
            samp_d[1] = rx_s;
        end else if (tick_q == 4'd8) begin
            samp_d[0] = rx_s;
        end else begin
            samp_d = samp_q;
        end

        case (state_q)
            ST_IDLE: begin
                bit_idx_d = 3'd0;
                if (!rx_s) begin
                    // This cycle is tick 0 of the start bit.
                    state_d = ST_START;
                    tick_d  = 4'd1;
                end else begin
                    tick_d  = 4'd0;
                end
            end
            ST_START: begin
                if ((tick_q == 4'd9) && vote_s) begin
                    // Line came back high mid start bit: false start.
                    state_d = ST_IDLE;
                    tick_d  = 4'd0;
                end else if (tick_q == 4'd15) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_q == 4'd9) begin
                    shift_d = {vote_s, shift_q[7:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (tick_q == 4'd15) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end
            ST_STOP: begin
                if (tick_q == 4'd9) begin
                    tick_d = 4'd0;
                    if (vote_s) begin
                        // Skip the second half of the stop bit so the next
                        // start edge is caught early.
                        commit_s = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_WAIT_HIGH: begin
                // Hold off until a break/low line releases, so it cannot retrigger.
                tick_d = 4'd0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = 4'd0;
            end
        endcase
    end

    // Host-side flags: a commit beats a simultaneous ack for data_ready,
    // and an ack on the commit cycle suppresses the overrun.
    always_comb begin
        data_d  = data_q;
        ready_d = ready_q;
        fe_d    = fe_q;
        ovr_d   = ovr_q;

        if (commit_s) begin
            data_d  = shift_q;
            ready_d = 1'b1;
        end else if (ack_in) begin
            ready_d = 1'b0;
        end else begin
            ready_d = ready_q;
        end

        if (ack_in) begin
            ovr_d = 1'b0;
        end else if (commit_s && ready_q) begin
            ovr_d = 1'b1;
        end else begin
            ovr_d = ovr_q;
        end

        if (frame_err_s) begin
            fe_d = 1'b1;
        end else if (ack_in) begin
            fe_d = 1'b0;
        end else begin
            fe_d = fe_q;
        end

        rcv_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge bit_clock_x16 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            tick_q    <= 4'd0;
            bit_idx_q <= 3'd0;
            samp_q    <= 2'b00;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            ready_q   <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            rcv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
            rcv_q     <= rcv_d;
        end
    end

    assign data_out      = data_q;
    assign data_ready    = ready_q;
    assign framing_error = fe_q;
    assign overrun       = ovr_q;
    assign receiving     = rcv_q;

endmodule
